// File: rtl/roc_pkg.sv
// Shared types and helpers for the rank-order-coding encoder: FSM state
// encoding, sort-order constants and the strict "better pixel" comparison.
package roc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    OFFER   = 2'd2,
    RELEASE = 2'd3
  } roc_state_t;

  localparam logic ROC_DESC = 1'b0;
  localparam logic ROC_ASC  = 1'b1;

  // Callers zero-extend their pixels to this width; PIXEL_BITS must not exceed it.
  localparam int ROC_CMP_BITS = 32;

  // Strictly better only, so an equal later pixel never displaces an earlier one.
  function automatic logic roc_better(input logic [ROC_CMP_BITS-1:0] a,
                                      input logic [ROC_CMP_BITS-1:0] b,
                                      input logic                    order);
    return (order == ROC_DESC) ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/roc_argmax_scan.sv
// Sequential arg-best search: walks one pixel per cycle from index 0 and keeps
// the best eligible, not-yet-emitted pixel. done/found/idx/val include the current pixel.
module roc_argmax_scan
  import roc_pkg::*;
#(
  parameter int IMAGE_SIZE = 784,
  parameter int PIXEL_BITS = 8,
  parameter int IDX_BITS   = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PIXEL_BITS-1:0] pixel,
  input  logic                  emitted,
  input  logic [PIXEL_BITS-1:0] threshold,
  input  logic                  order,
  output logic [IDX_BITS-1:0]   scan_idx,
  output logic                  done,
  output logic                  found,
  output logic [IDX_BITS-1:0]   idx,
  output logic [PIXEL_BITS-1:0] val
);

  logic                  running;
  logic                  best_valid;
  logic [IDX_BITS-1:0]   best_idx;
  logic [PIXEL_BITS-1:0] best_val;
  logic                  eligible;
  logic                  take;
  logic                  last;

  always_comb begin
    eligible = (order == ROC_DESC) ? (pixel >= threshold) : (pixel <= threshold);
    take     = running && !emitted && eligible &&
               (!best_valid || roc_better(ROC_CMP_BITS'(pixel), ROC_CMP_BITS'(best_val), order));
    last     = (scan_idx == IDX_BITS'(IMAGE_SIZE - 1));
    done     = running && last;
    found    = best_valid || take;
    idx      = take ? scan_idx : best_idx;
    val      = take ? pixel : best_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running    <= 1'b0;
      scan_idx   <= '0;
      best_valid <= 1'b0;
      best_idx   <= '0;
      best_val   <= '0;
    end else if (start) begin
      running    <= 1'b1;
      scan_idx   <= '0;
      best_valid <= 1'b0;
    end else if (running) begin
      if (take) begin
        best_valid <= 1'b1;
        best_idx   <= scan_idx;
        best_val   <= pixel;
      end
      if (last) begin
        running <= 1'b0;
      end else begin
        scan_idx <= scan_idx + IDX_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/roc_topk_encoder.sv
// Rank-order-coding encoder: latches an image and offers pixel indices one at a
// time in intensity order, with threshold cut-off, top-K limit and abort.
module roc_topk_encoder
  import roc_pkg::*;
#(
  parameter int IMAGE_SIZE = 784,
  parameter int PIXEL_BITS = 8,
  parameter int IDX_BITS   = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [PIXEL_BITS-1:0] IMAGE [0:IMAGE_SIZE-1],
  input  logic                  NEW_IMAGE,
  input  logic                  ORDER,
  input  logic [PIXEL_BITS-1:0] THRESHOLD,
  input  logic [IDX_BITS:0]     TOPK,
  input  logic                  ABORT,
  input  logic                  AERIN_CTRL_BUSY,
  output logic [9:0]            NEXT_INDEX,
  output logic [PIXEL_BITS-1:0] NEXT_VALUE,
  output logic                  FOUND_NEXT_INDEX,
  output logic [IDX_BITS:0]     SPIKE_COUNT,
  output logic                  ENCODER_RDY,
  output logic                  ENCODE_DONE,
  output logic [1:0]            fsm_state
);

  localparam int CW = IDX_BITS + 1;

  // Handshake: an offer (FOUND_NEXT_INDEX with NEXT_INDEX/NEXT_VALUE) is held
  // stable until AERIN_CTRL_BUSY=1 is sampled, which consumes it; the next scan
  // only begins after AERIN_CTRL_BUSY=0 is sampled again.

  roc_state_t            state_q, state_d;
  logic [PIXEL_BITS-1:0] img_q [0:IMAGE_SIZE-1];
  logic                  order_q;
  logic [PIXEL_BITS-1:0] thr_q;
  logic [CW-1:0]         topk_q;
  logic [IMAGE_SIZE-1:0] emitted_q;
  logic [IDX_BITS-1:0]   offer_idx_q;
  logic                  restart_q;

  logic                  load, start_scan, offer, accept, finish, rescan;
  logic                  scan_clear;
  logic [IDX_BITS-1:0]   scan_idx, scan_best_idx;
  logic                  scan_done, scan_found;
  logic [PIXEL_BITS-1:0] scan_best_val;

  assign scan_clear = RST || ABORT;
  assign NEXT_INDEX = 10'(offer_idx_q);
  assign fsm_state  = state_q;

  roc_argmax_scan #(
    .IMAGE_SIZE (IMAGE_SIZE),
    .PIXEL_BITS (PIXEL_BITS),
    .IDX_BITS   (IDX_BITS)
  ) u_scan (
    .clk       (CLK),
    .rst       (scan_clear),
    .start     (start_scan),
    .pixel     (img_q[scan_idx]),
    .emitted   (emitted_q[scan_idx]),
    .threshold (thr_q),
    .order     (order_q),
    .scan_idx  (scan_idx),
    .done      (scan_done),
    .found     (scan_found),
    .idx       (scan_best_idx),
    .val       (scan_best_val)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    start_scan = 1'b0;
    offer      = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    rescan     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (NEW_IMAGE) begin
          load       = 1'b1;
          start_scan = 1'b1;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        // A rescan spends its first cycle rearming the scanner.
        if (restart_q) begin
          start_scan = 1'b1;
        end else if (scan_done) begin
          if (scan_found) begin
            offer   = 1'b1;
            state_d = OFFER;
          end else begin
            finish  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      OFFER: begin
        if (AERIN_CTRL_BUSY) begin
          accept  = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!AERIN_CTRL_BUSY) begin
          if (topk_q != '0 && SPIKE_COUNT == topk_q) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            rescan  = 1'b1;
            state_d = SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (ABORT) begin
      state_d    = IDLE;
      load       = 1'b0;
      start_scan = 1'b0;
      offer      = 1'b0;
      accept     = 1'b0;
      finish     = 1'b0;
      rescan     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (load) begin
      img_q   <= IMAGE;
      order_q <= ORDER;
      thr_q   <= THRESHOLD;
      topk_q  <= TOPK;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      FOUND_NEXT_INDEX <= 1'b0;
      ENCODE_DONE      <= 1'b0;
      ENCODER_RDY      <= 1'b1;
      NEXT_VALUE       <= '0;
      SPIKE_COUNT      <= '0;
      offer_idx_q      <= '0;
      emitted_q        <= '0;
      restart_q        <= 1'b0;
    end else begin
      ENCODE_DONE <= finish;
      restart_q   <= rescan;
      if (ABORT) begin
        FOUND_NEXT_INDEX <= 1'b0;
        ENCODER_RDY      <= 1'b1;
      end
      if (load) begin
        emitted_q   <= '0;
        SPIKE_COUNT <= '0;
        ENCODER_RDY <= 1'b0;
      end
      if (offer) begin
        FOUND_NEXT_INDEX <= 1'b1;
        offer_idx_q      <= scan_best_idx;
        NEXT_VALUE       <= scan_best_val;
      end
      if (accept) begin
        FOUND_NEXT_INDEX       <= 1'b0;
        emitted_q[offer_idx_q] <= 1'b1;
        SPIKE_COUNT            <= SPIKE_COUNT + CW'(1);
      end
      if (finish) begin
        ENCODER_RDY <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_roc_topk_encoder.sv
// Directed bench for roc_topk_encoder on a 7-pixel image; offers are checked
// by a monitor against an expected queue filled by the stimulus side.
module tb_roc_topk_encoder;

  localparam int N  = 7;
  localparam int PB = 8;
  localparam int IB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [PB-1:0] image [0:N-1];
  logic          new_image;
  logic          order;
  logic [PB-1:0] threshold;
  logic [IB:0]   topk;
  logic          abort;
  logic          busy;
  logic [9:0]    next_index;
  logic [PB-1:0] next_value;
  logic          found;
  logic [IB:0]   spike_count;
  logic          encoder_rdy;
  logic          encode_done;
  logic [1:0]    fsm_state;

  roc_topk_encoder #(.IMAGE_SIZE(N), .PIXEL_BITS(PB), .IDX_BITS(IB)) dut (
    .CLK              (clk),
    .RST              (rst),
    .IMAGE            (image),
    .NEW_IMAGE        (new_image),
    .ORDER            (order),
    .THRESHOLD        (threshold),
    .TOPK             (topk),
    .ABORT            (abort),
    .AERIN_CTRL_BUSY  (busy),
    .NEXT_INDEX       (next_index),
    .NEXT_VALUE       (next_value),
    .FOUND_NEXT_INDEX (found),
    .SPIKE_COUNT      (spike_count),
    .ENCODER_RDY      (encoder_rdy),
    .ENCODE_DONE      (encode_done),
    .fsm_state        (fsm_state)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;
  logic        found_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every rising offer pops one expected {index, value}.
  always @(posedge clk) begin
    #1;
    if (encode_done) done_cnt++;
    if (found && !found_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_offer", {22'd0, next_index}, 32'd1023);
      end else begin
        mon_e = exp_q.pop_front();
        check("offer_idx", {22'd0, next_index}, {22'd0, mon_e[17:8]});
        check("offer_val", {24'd0, next_value}, {24'd0, mon_e[7:0]});
      end
    end
    found_prev = found;
  end

  task automatic push(input int idx, input int val);
    exp_q.push_back({10'(idx), 8'(val)});
  endtask

  task automatic start_image(input logic ord, input logic [PB-1:0] thr, input logic [IB:0] k);
    @(negedge clk);
    order = ord; threshold = thr; topk = k; new_image = 1'b1;
    @(posedge clk);
    #1 new_image = 1'b0;
  endtask

  task automatic wait_event(output int n, output logic f, output logic d);
    n = 0; f = 1'b0; d = 1'b0;
    while (!f && !d && n < 200) begin
      @(posedge clk); #1;
      n++;
      f = found;
      d = encode_done;
    end
    if (!f && !d) begin
      n_checks++;
      $display("FAIL event_timeout: no offer or done within %0d cycles", n);
    end
  endtask

  task automatic serve(input int delay, input int hold);
    repeat (delay) @(negedge clk);
    @(negedge clk) busy = 1'b1;
    repeat (hold) @(negedge clk);
    busy = 1'b0;
  endtask

  task automatic drain(input string tag, input int spikes, input int done_lat);
    int n; logic f, d;
    for (int s = 0; s < spikes; s++) begin
      serve(0, 2);
      wait_event(n, f, d);
      if (s < spikes - 1) begin
        check({tag, "_found"}, 32'(f), 32'd1);
        check({tag, "_lat"}, n, 32'd9);
      end else begin
        check({tag, "_done"}, 32'(d), 32'd1);
        check({tag, "_done_lat"}, n, done_lat);
      end
    end
  endtask

  initial begin
    int   n;
    logic f, d;
    logic ok;
    logic [PB-1:0] saved [0:N-1];

    rst = 1'b1; new_image = 1'b0; order = 1'b0; threshold = '0; topk = '0;
    abort = 1'b0; busy = 1'b0;
    image = '{8'd10, 8'd200, 8'd50, 8'd200, 8'd0, 8'd255, 8'd7};
    repeat (3) @(negedge clk);
    check("rst_found", 32'(found), 32'd0);
    check("rst_done", 32'(encode_done), 32'd0);
    check("rst_index", 32'(next_index), 32'd0);
    check("rst_value", 32'(next_value), 32'd0);
    check("rst_count", 32'(spike_count), 32'd0);
    check("rst_rdy", 32'(encoder_rdy), 32'd1);
    check("rst_state", 32'(fsm_state), 32'd0);
    rst = 1'b0;

    // Test 1: descending, no threshold, unlimited.
    push(5, 255); push(1, 200); push(3, 200); push(2, 50);
    push(0, 10); push(6, 7); push(4, 0);
    start_image(1'b0, 8'd0, 4'd0);
    check("t1_rdy_low", 32'(encoder_rdy), 32'd0);
    wait_event(n, f, d);
    check("t1_first_lat", n, 32'd7);
    drain("t1", 7, 9);
    check("t1_count", 32'(spike_count), 32'd7);
    check("t1_rdy", 32'(encoder_rdy), 32'd1);
    @(posedge clk); #1;
    check("t1_done_pulse_width", 32'(encode_done), 32'd0);

    // Test 2: threshold 50 keeps four pixels.
    push(5, 255); push(1, 200); push(3, 200); push(2, 50);
    start_image(1'b0, 8'd50, 4'd0);
    wait_event(n, f, d);
    check("t2_first_lat", n, 32'd7);
    drain("t2", 4, 9);
    check("t2_count", 32'(spike_count), 32'd4);

    // Test 3: ascending with top-3 limit.
    push(4, 0); push(6, 7); push(0, 10);
    start_image(1'b1, 8'd255, 4'd3);
    wait_event(n, f, d);
    check("t3_first_found", 32'(f), 32'd1);
    drain("t3", 3, 1);
    check("t3_count", 32'(spike_count), 32'd3);

    // Test 4: handshake stalls and ignored mid-scan NEW_IMAGE.
    push(5, 255); push(1, 200);
    start_image(1'b0, 8'd0, 4'd2);
    wait_event(n, f, d);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      ok &= (found === 1'b1) && (next_index === 10'd5) && (next_value === 8'd255);
    end
    check("t4_offer_hold", 32'(ok), 32'd1);
    @(negedge clk) busy = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      ok &= (found === 1'b0) && (fsm_state === 2'd3);
    end
    check("t4_release_hold", 32'(ok), 32'd1);
    @(negedge clk) busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    saved = image;
    image = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    new_image = 1'b1;
    @(negedge clk);
    new_image = 1'b0;
    image = saved;
    wait_event(n, f, d);
    check("t4_second_found", 32'(f), 32'd1);
    serve(0, 1);
    wait_event(n, f, d);
    check("t4_done", 32'(d), 32'd1);
    check("t4_done_lat", n, 32'd1);
    check("t4_count", 32'(spike_count), 32'd2);

    // Test 5a: abort while scan_idx = 3.
    start_image(1'b0, 8'd0, 4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk); #1;
    check("t5_abort_rdy", 32'(encoder_rdy), 32'd1);
    check("t5_abort_state", 32'(fsm_state), 32'd0);
    @(negedge clk) abort = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      ok &= (found === 1'b0) && (encode_done === 1'b0);
    end
    check("t5_abort_quiet", 32'(ok), 32'd1);
    check("t5_abort_count", 32'(spike_count), 32'd0);

    // Test 5b: reset while an offer is pending.
    push(5, 255); push(1, 200);
    start_image(1'b0, 8'd0, 4'd0);
    wait_event(n, f, d);
    serve(0, 2);
    wait_event(n, f, d);
    check("t5_pre_rst_count", 32'(spike_count), 32'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_found", 32'(found), 32'd0);
    check("t5_rst_index", 32'(next_index), 32'd0);
    check("t5_rst_value", 32'(next_value), 32'd0);
    check("t5_rst_count", 32'(spike_count), 32'd0);
    check("t5_rst_rdy", 32'(encoder_rdy), 32'd1);
    check("t5_rst_state", 32'(fsm_state), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Test 5c: normal image after reset.
    push(5, 255); push(1, 200); push(3, 200);
    start_image(1'b0, 8'd200, 4'd0);
    wait_event(n, f, d);
    check("t5c_first_lat", n, 32'd7);
    drain("t5c", 3, 9);
    check("t5c_count", 32'(spike_count), 32'd3);

    // Test 6: nothing eligible.
    image = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    start_image(1'b0, 8'd1, 4'd0);
    wait_event(n, f, d);
    check("t6_done", 32'(d), 32'd1);
    check("t6_no_found", 32'(f), 32'd0);
    check("t6_done_lat", n, 32'd7);
    check("t6_rdy", 32'(encoder_rdy), 32'd1);
    check("t6_count", 32'(spike_count), 32'd0);

    @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    check("done_pulses", done_cnt, 32'd6);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/roc_topk_encoder.md
# roc_topk_encoder

Parametrised rank-order-coding (ROC) encoder: latches an input image, then emits pixel indices one at a time in intensity order toward the AER input controller. It sits between image load and the AER input link. It generalises the existing ROC encoder with three additions: selectable sort order, an intensity threshold cutting off low-rank pixels, and a runtime top-K spike limit. It also reports the emitted pixel value, the spike count, a done pulse, and accepts a synchronous abort.

## Interface
Parameters:
- IMAGE_SIZE, 784: number of pixels (≥1).
- PIXEL_BITS, 8: pixel width.
- IDX_BITS, max(1,$clog2(IMAGE_SIZE)): index width; NEXT_INDEX is zero-extended to 10 bits.

Ports:
- CLK  in  1  clock; one clock domain.
- RST  in  1  reset, synchronous, active-high.
- IMAGE  in  PIXEL_BITS×[0:IMAGE_SIZE-1]  pixel array, sampled only with NEW_IMAGE.
- NEW_IMAGE  in  1  start request; sampled only in IDLE.
- ORDER  in  1  0 = descending (brightest first), 1 = ascending; latched with NEW_IMAGE.
- THRESHOLD  in  PIXEL_BITS  eligibility bound, latched with NEW_IMAGE.
  - Descending: a pixel is eligible if value ≥ THRESHOLD.
  - Ascending: a pixel is eligible if value ≤ THRESHOLD.
- TOPK  in  IDX_BITS+1  max spikes per image, latched with NEW_IMAGE; 0 = unlimited.
- ABORT  in  1  synchronous abort to IDLE.
- AERIN_CTRL_BUSY  in  1  AER controller busy/ack.
- NEXT_INDEX  out  10  index offered.
- NEXT_VALUE  out  PIXEL_BITS  pixel value offered.
- FOUND_NEXT_INDEX  out  1  offer valid.
- SPIKE_COUNT  out  IDX_BITS+1  spikes accepted for the current image.
- ENCODER_RDY  out  1  idle, ready for an image.
- ENCODE_DONE  out  1  one-cycle pulse at end of image.

## Operation
- FSM states: IDLE, SCAN, OFFER, RELEASE.
- **IDLE:** ENCODER_RDY = 1. On NEW_IMAGE:
  - Latch IMAGE, ORDER, THRESHOLD and TOPK.
  - Clear the emitted bitmap (IMAGE_SIZE bits) and SPIKE_COUNT.
  - ENCODER_RDY ← 0; enter SCAN with scan_idx = 0 and best_valid = 0.
- **SCAN:** evaluates one pixel per cycle, scan_idx 0 → IMAGE_SIZE-1.
  - A candidate needs emitted = 0 and eligibility.
  - It replaces the current best only if strictly better: > for descending, < for ascending. Ties therefore go to the lowest index.
  - After the last pixel, if best_valid: go to OFFER, set FOUND_NEXT_INDEX = 1 and drive NEXT_INDEX/NEXT_VALUE.
  - Otherwise: end of image.
- **OFFER:** FOUND, NEXT_INDEX and NEXT_VALUE are held stable until AERIN_CTRL_BUSY = 1 is sampled. On that edge:
  - FOUND ← 0.
  - emitted[idx] ← 1.
  - SPIKE_COUNT += 1.
  - Go to RELEASE.
- **RELEASE:** wait until AERIN_CTRL_BUSY = 0 is sampled.
  - If TOPK ≠ 0 and SPIKE_COUNT == TOPK: end of image.
  - Otherwise: re-enter SCAN from index 0.
- **End of image:** go to IDLE; ENCODER_RDY ← 1; ENCODE_DONE pulses for 1 cycle. SPIKE_COUNT holds until the next NEW_IMAGE.
- **ABORT** (any state, priority over everything except RST):
  - Next state is IDLE; FOUND ← 0; ENCODER_RDY ← 1.
  - No ENCODE_DONE pulse.
  - The emitted bitmap and SPIKE_COUNT hold their values.
- NEW_IMAGE outside IDLE is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - FOUND_NEXT_INDEX = 0, ENCODE_DONE = 0.
  - NEXT_INDEX = 0, NEXT_VALUE = 0, SPIKE_COUNT = 0.
  - ENCODER_RDY = 1; state = IDLE.
- RST mid-operation forces these values on the next edge.
- Let edge e0 sample NEW_IMAGE = 1. Then FOUND_NEXT_INDEX rises at edge e0+IMAGE_SIZE.
- Per-spike latency, from the busy-low edge in RELEASE to FOUND rising: IMAGE_SIZE+1 edges.
- No-eligible-pixel image: ENCODE_DONE and ENCODER_RDY assert at edge e0+IMAGE_SIZE.
- Busy already high when OFFER is entered: accepted on the first OFFER cycle.
- Busy never dropping: the block stays in RELEASE indefinitely.
- At most IMAGE_SIZE spikes per image; once every pixel is emitted, the next scan finds none.
- All comparisons are unsigned, PIXEL_BITS wide. The counters cannot overflow because of the IDX_BITS+1 width.

## Structure
- Package roc_pkg holds:
  - The state enum typedef (IDLE, SCAN, OFFER, RELEASE).
  - Order constants: ROC_DESC = 0, ROC_ASC = 1.
  - A helper function roc_better(a, b, order) implementing the strict comparison.
- One sub-module, roc_argmax_scan, holds scan_idx, best_idx, best_val and best_valid. Its interface:
  - Inputs: start, pixel, emitted bit, threshold, order.
  - Outputs: done, found, idx, val.
- The FSM, emitted bitmap, counters and handshake live in the top module.

## Test plan
Configuration: IMAGE_SIZE = 7, PIXEL_BITS = 8, image {10,200,50,200,0,255,7}.
1. ORDER = 0, THRESHOLD = 0, TOPK = 0, busy held 2 cycles per spike → indices 5,1,3,2,0,6,4 and values 255,200,200,50,10,7,0; SPIKE_COUNT = 7; one ENCODE_DONE pulse.
2. ORDER = 0, THRESHOLD = 50 → indices 5,1,3,2 only; SPIKE_COUNT = 4.
3. ORDER = 1, THRESHOLD = 255, TOPK = 3 → indices 4,6,0; ENCODE_DONE on the busy-low edge after the 3rd spike.
4. Handshake stalls:
   - Busy held low 20 cycles in OFFER → FOUND stays 1 and NEXT_INDEX stays 5.
   - Busy held high 10 cycles → no scan starts until busy falls.
   - NEW_IMAGE pulsed mid-scan → ignored.
5. ABORT at scan_idx = 3 → ENCODER_RDY = 1 next edge, no FOUND, no ENCODE_DONE. RST in OFFER → all reset values. A subsequent NEW_IMAGE is processed normally.
6. All-zero image, ORDER = 0, THRESHOLD = 1 → no FOUND; ENCODE_DONE and ENCODER_RDY at edge e0+7; SPIKE_COUNT = 0.
